// File: rtl/bus_hs_fifo_if.sv
// Valid/ready handshake bundle for the bus elastic buffer.
// The buffer uses the slave view; the source/destination driver uses the master view.
interface bus_hs_fifo_if #(
    parameter int DATA_W = 8
);
    logic              s_valid_i;
    logic [DATA_W-1:0] s_data_i;
    logic              s_ready_o;
    logic              m_valid_o;
    logic [DATA_W-1:0] m_data_o;
    logic              m_ready_i;

    modport slave (
        input  s_valid_i,
        input  s_data_i,
        input  m_ready_i,
        output s_ready_o,
        output m_valid_o,
        output m_data_o
    );

    modport master (
        output s_valid_i,
        output s_data_i,
        output m_ready_i,
        input  s_ready_o,
        input  m_valid_o,
        input  m_data_o
    );
endinterface

// File: rtl/bus_hs_fifo.sv
// First-word-fall-through valid/ready elastic buffer with occupancy, almost-full
// and beat counters. Handshake flags are registered; no input-to-ready path.
module bus_hs_fifo #(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 4,
    parameter int AFULL_TH = 3
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       clear_i,
    bus_hs_fifo_if.slave               bus,
    output logic [$clog2(DEPTH):0]     level_o,
    output logic                       afull_o,
    output logic [15:0]                in_cnt_o,
    output logic [15:0]                out_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     level_q, level_d;
    logic              s_ready_q, s_ready_d;
    logic              m_valid_q, m_valid_d;
    logic              afull_q, afull_d;
    logic [15:0]       in_cnt_q, in_cnt_d;
    logic [15:0]       out_cnt_q, out_cnt_d;
    logic              push_s;
    logic              pop_s;

    // Next-state: pointer/counter advance, flush, and flags derived from next level
    always_comb begin
        push_s    = bus.s_valid_i & s_ready_q;
        pop_s     = m_valid_q & bus.m_ready_i;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        in_cnt_d  = in_cnt_q;
        out_cnt_d = out_cnt_q;
        if (clear_i) begin
            wr_ptr_d  = {PW{1'b0}};
            rd_ptr_d  = {PW{1'b0}};
            in_cnt_d  = 16'd0;
            out_cnt_d = 16'd0;
        end else begin
            if (push_s) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
                in_cnt_d = in_cnt_q + 16'd1;
            end else begin
                wr_ptr_d = wr_ptr_q;
                in_cnt_d = in_cnt_q;
            end
            if (pop_s) begin
                rd_ptr_d  = rd_ptr_q + PW'(1);
                out_cnt_d = out_cnt_q + 16'd1;
            end else begin
                rd_ptr_d  = rd_ptr_q;
                out_cnt_d = out_cnt_q;
            end
        end
        // Wrap bit makes the modular difference distinguish full from empty
        level_d   = wr_ptr_d - rd_ptr_d;
        m_valid_d = (level_d != {PW{1'b0}});
        s_ready_d = (level_d != PW'(DEPTH));
        afull_d   = (level_d >= PW'(AFULL_TH));
    end

    // Control state registers with asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q  <= {PW{1'b0}};
            rd_ptr_q  <= {PW{1'b0}};
            level_q   <= {PW{1'b0}};
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            afull_q   <= 1'b0;
            in_cnt_q  <= 16'd0;
            out_cnt_q <= 16'd0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            level_q   <= level_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            afull_q   <= afull_d;
            in_cnt_q  <= in_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end

    // Storage array; contents are never reset
    always_ff @(posedge clk) begin
        if (push_s && !clear_i) begin
            mem_q[wr_ptr_q[AW-1:0]] <= bus.s_data_i;
        end
    end

    assign bus.s_ready_o = s_ready_q;
    assign bus.m_valid_o = m_valid_q;
    assign bus.m_data_o  = m_valid_q ? mem_q[rd_ptr_q[AW-1:0]] : {DATA_W{1'b0}};
    assign level_o       = level_q;
    assign afull_o       = afull_q;
    assign in_cnt_o      = in_cnt_q;
    assign out_cnt_o     = out_cnt_q;
endmodule

// File: tb/tb_bus_hs_fifo.sv
// Directed bench for bus_hs_fifo (DEPTH=4, AFULL_TH=3): a queue scoreboard holds
// accepted beats and is checked against every delivered beat and status output.
module tb_bus_hs_fifo;
    logic        clk;
    logic        rst_n;
    logic        clear_i;
    logic [2:0]  level_o;
    logic        afull_o;
    logic [15:0] in_cnt_o;
    logic [15:0] out_cnt_o;

    bus_hs_fifo_if #(.DATA_W(8)) bus ();

    bus_hs_fifo #(.DATA_W(8), .DEPTH(4), .AFULL_TH(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clear_i   (clear_i),
        .bus       (bus.slave),
        .level_o   (level_o),
        .afull_o   (afull_o),
        .in_cnt_o  (in_cnt_o),
        .out_cnt_o (out_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          passed = 0;
    int          total  = 0;
    logic [7:0]  sb_q[$];
    logic [15:0] exp_in;
    logic [15:0] exp_out;
    bit          exp_rdy;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic model_reset();
        sb_q.delete();
        exp_in  = 16'd0;
        exp_out = 16'd0;
        exp_rdy = 1'b0;
    endtask

    // One clock: predict the handshake from the model, then check every output
    task automatic cycle();
        bit psh;
        bit pp;
        psh = bus.s_valid_i && exp_rdy && !clear_i;
        pp  = (sb_q.size() != 0) && bus.m_ready_i && !clear_i;
        if (pp) chk("pop_data", {24'd0, bus.m_data_o}, {24'd0, sb_q[0]});
        @(posedge clk);
        #1;
        if (clear_i) begin
            sb_q.delete();
            exp_in  = 16'd0;
            exp_out = 16'd0;
        end else begin
            if (pp) begin
                void'(sb_q.pop_front());
                exp_out = exp_out + 16'd1;
            end
            if (psh) begin
                sb_q.push_back(bus.s_data_i);
                exp_in = exp_in + 16'd1;
            end
        end
        exp_rdy = (sb_q.size() != 4);
        chk("level",   {29'd0, level_o},       sb_q.size());
        chk("m_valid", {31'd0, bus.m_valid_o}, {31'd0, sb_q.size() != 0});
        chk("s_ready", {31'd0, bus.s_ready_o}, {31'd0, exp_rdy});
        chk("afull",   {31'd0, afull_o},       {31'd0, sb_q.size() >= 3});
        chk("in_cnt",  {16'd0, in_cnt_o},      {16'd0, exp_in});
        chk("out_cnt", {16'd0, out_cnt_o},     {16'd0, exp_out});
        if (sb_q.size() != 0) chk("head_data", {24'd0, bus.m_data_o}, {24'd0, sb_q[0]});
        else                  chk("idle_data", {24'd0, bus.m_data_o}, 32'd0);
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic r, input logic c);
        bus.s_valid_i = v;
        bus.s_data_i  = d;
        bus.m_ready_i = r;
        clear_i       = c;
    endtask

    initial begin
        rst_n = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_s_ready", {31'd0, bus.s_ready_o}, 32'd0);
        chk("rst_m_valid", {31'd0, bus.m_valid_o}, 32'd0);
        chk("rst_m_data",  {24'd0, bus.m_data_o},  32'd0);
        chk("rst_level",   {29'd0, level_o},       32'd0);
        chk("rst_afull",   {31'd0, afull_o},       32'd0);
        chk("rst_in_cnt",  {16'd0, in_cnt_o},      32'd0);
        chk("rst_out_cnt", {16'd0, out_cnt_o},     32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // 1: ready one edge after release, then a single beat falls through
        cycle();
        chk("t1_ready_after_release", {31'd0, bus.s_ready_o}, 32'd1);
        drive(1'b1, 8'h05, 1'b0, 1'b0);
        cycle();
        chk("t1_m_data", {24'd0, bus.m_data_o}, 32'h05);
        chk("t1_level",  {29'd0, level_o},      32'd1);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        cycle();

        // 2: fill to DEPTH, then a fifth beat must be held off
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 8'(i), 1'b0, 1'b0);
            cycle();
        end
        chk("t2_level_full", {29'd0, level_o},       32'd4);
        chk("t2_ready_full", {31'd0, bus.s_ready_o}, 32'd0);
        chk("t2_afull",      {31'd0, afull_o},       32'd1);
        drive(1'b1, 8'h05, 1'b0, 1'b0);
        cycle();
        cycle();
        chk("t2_not_accepted", {29'd0, level_o}, 32'd4);

        // 3: one pop from full, then the held beat enters
        drive(1'b1, 8'h05, 1'b1, 1'b0);
        cycle();
        chk("t3_level",   {29'd0, level_o},       32'd3);
        chk("t3_ready",   {31'd0, bus.s_ready_o}, 32'd1);
        chk("t3_afull",   {31'd0, afull_o},       32'd1);
        chk("t3_head",    {24'd0, bus.m_data_o},  32'h02);
        drive(1'b1, 8'h05, 1'b0, 1'b0);
        cycle();
        chk("t3_refill", {29'd0, level_o}, 32'd4);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        repeat (4) cycle();

        // 4: streaming 20 beats from zeroed counters
        drive(1'b0, 8'h00, 1'b0, 1'b1);
        cycle();
        for (int i = 0; i < 20; i++) begin
            drive(1'b1, 8'(i), 1'b1, 1'b0);
            cycle();
            chk("t4_steady_level", {29'd0, level_o}, 32'd1);
        end
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        cycle();
        chk("t4_in_cnt",  {16'd0, in_cnt_o},  32'd20);
        chk("t4_out_cnt", {16'd0, out_cnt_o}, 32'd20);

        // 5: clear beats a simultaneous push and pop
        drive(1'b1, 8'h11, 1'b0, 1'b0);
        cycle();
        drive(1'b1, 8'h22, 1'b0, 1'b0);
        cycle();
        chk("t5_level2", {29'd0, level_o}, 32'd2);
        drive(1'b1, 8'hAA, 1'b1, 1'b1);
        cycle();
        chk("t5_level",   {29'd0, level_o},       32'd0);
        chk("t5_m_valid", {31'd0, bus.m_valid_o}, 32'd0);
        chk("t5_in_cnt",  {16'd0, in_cnt_o},      32'd0);
        chk("t5_out_cnt", {16'd0, out_cnt_o},     32'd0);
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        cycle();
        chk("t5_beat_dropped", {29'd0, level_o}, 32'd0);

        // 6: asynchronous reset in the middle of a burst
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 8'h30 + 8'(i), 1'b0, 1'b0);
            cycle();
        end
        chk("t6_level3", {29'd0, level_o}, 32'd3);
        drive(1'b1, 8'h40, 1'b1, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("t6_async_m_valid", {31'd0, bus.m_valid_o}, 32'd0);
        chk("t6_async_s_ready", {31'd0, bus.s_ready_o}, 32'd0);
        chk("t6_async_level",   {29'd0, level_o},       32'd0);
        model_reset();
        drive(1'b0, 8'h00, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        cycle();
        drive(1'b1, 8'h77, 1'b0, 1'b0);
        cycle();
        chk("t6_resume_head", {24'd0, bus.m_data_o}, 32'h77);
        drive(1'b0, 8'h00, 1'b1, 1'b0);
        cycle();
        chk("t6_resume_empty", {29'd0, level_o}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
